lc4_multiplier_seq: RTL

Sequential unsigned 16x16 multiplier for the LC4 ALU's MUL path. It is the inverse-direction companion to the combinational divider.
- Radix-2 shift-add; one multiplier bit retired per clock.
- Produces a full 32-bit product; LC4 MUL consumes the low word.
- Valid/ready handshake on both sides, so the ALU/pipeline can stall on it.

---
 rtl/lc4_multiplier_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/lc4_multiplier_seq.sv
// Sequential radix-2 shift-add unsigned multiplier for the LC4 MUL path.
// One multiplier bit is retired per clock; the full 2*WIDTH product is kept.
module lc4_multiplier_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_multiplicand,
  input  logic [WIDTH-1:0] i_multiplier,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_product_lo,
  output logic [WIDTH-1:0] o_product_hi,
  output logic             o_busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     sum;
  logic               last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
    end
  end

  assign last = (count_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The sum keeps the carry so 0xFFFF*0xFFFF stays exact after the shift.
  always_comb begin
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    if (state_q == IDLE && i_valid) begin
      mcand_d  = i_multiplicand;
      mplier_d = i_multiplier;
      acc_d    = '0;
      count_d  = '0;
    end else if (state_q == RUN) begin
      acc_d    = {sum, acc_q[WIDTH-1:1]};
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CW'(1);
      if (last) prod_d = acc_d;
    end
  end

  always_comb begin
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      IDLE:    o_ready = 1'b1;
      RUN:     o_busy  = 1'b1;
      DONE:    o_valid = 1'b1;
      default: ;
    endcase
  end

  assign o_product_lo = prod_q[WIDTH-1:0];
  assign o_product_hi = prod_q[2*WIDTH-1:WIDTH];

endmodule
